// File: rtl/vxe_mem_hub_cu_ds_if.sv
// Response-path bundle between the two master response FIFOs, the hub merge stage and the CU response FIFO.
// The slave modport is the merge stage; the master modport is its environment.
interface vxe_mem_hub_cu_ds_if;
    logic        i_m0_rss_vld;
    logic [69:0] i_m0_rss;
    logic        o_m0_rss_rd;
    logic        i_m1_rss_vld;
    logic [69:0] i_m1_rss;
    logic        o_m1_rss_rd;
    logic        i_rss_rdy;
    logic [69:0] o_rss;
    logic        o_rss_wr;

    modport slave (
        input  i_m0_rss_vld, i_m0_rss, i_m1_rss_vld, i_m1_rss, i_rss_rdy,
        output o_m0_rss_rd, o_m1_rss_rd, o_rss, o_rss_wr
    );

    modport master (
        output i_m0_rss_vld, i_m0_rss, i_m1_rss_vld, i_m1_rss, i_rss_rdy,
        input  o_m0_rss_rd, o_m1_rss_rd, o_rss, o_rss_wr
    );
endinterface

// File: rtl/vxe_mem_hub_cu_ds.sv
// Merges Master 0/1 read responses into one CU response FIFO via round-robin and a 2-entry buffer.
// Latency 1 cycle (pop in N, presented in N+1); CU stall fills the buffer, then master pops stop.
module vxe_mem_hub_cu_ds (
    input  logic                   clk,
    input  logic                   nrst,
    vxe_mem_hub_cu_ds_if.slave     rss_if
);

    logic [1:0]  cnt_q, cnt_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        last_grant_q, last_grant_d;
    logic [69:0] mem_q [2];
    logic [69:0] mem_d [2];

    logic        accept;
    logic        grant_m1;
    logic        push;
    logic        pop;
    logic [69:0] push_dat;

    always_comb begin
        accept   = (cnt_q != 2'd2);
        // Both valid: favour the master that did not win last time.
        grant_m1 = rss_if.i_m1_rss_vld && (!rss_if.i_m0_rss_vld || !last_grant_q);
        // nrst gating keeps the pop strobes low for the whole reset pulse, not just after an edge.
        push     = nrst && accept && (rss_if.i_m0_rss_vld || rss_if.i_m1_rss_vld);
        pop      = (cnt_q != 2'd0) && rss_if.i_rss_rdy;
        push_dat = grant_m1 ? rss_if.i_m1_rss : rss_if.i_m0_rss;

        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        mem_d[0]     = mem_q[0];
        mem_d[1]     = mem_q[1];

        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
            last_grant_d    = grant_m1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            last_grant_q <= 1'b1;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            mem_q[0]     <= mem_d[0];
            mem_q[1]     <= mem_d[1];
        end
    end

    assign rss_if.o_m0_rss_rd = push && !grant_m1;
    assign rss_if.o_m1_rss_rd = push && grant_m1;
    assign rss_if.o_rss       = mem_q[rd_ptr_q];
    assign rss_if.o_rss_wr    = pop;

endmodule

// File: tb/tb_vxe_mem_hub_cu_ds.sv
// Randomized scoreboard bench for the CU downstream response merge.
module tb_vxe_mem_hub_cu_ds;

    logic clk;
    logic nrst;

    vxe_mem_hub_cu_ds_if bif ();

    vxe_mem_hub_cu_ds dut (
        .clk    (clk),
        .nrst   (nrst),
        .rss_if (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [69:0] src0 [$];
    logic [69:0] src1 [$];
    logic [69:0] exp_q [$];
    int          m_cnt  = 0;
    bit          m_last = 1'b1;
    bit          rdy_v  = 1'b1;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [69:0] rnd_word();
        logic [5:0] cid;
        cid = 6'($urandom);
        return {cid, $urandom, $urandom};
    endfunction

    task automatic drive();
        bif.i_m0_rss_vld = (src0.size() > 0);
        bif.i_m0_rss     = (src0.size() > 0) ? src0[0] : 70'h0;
        bif.i_m1_rss_vld = (src1.size() > 0);
        bif.i_m1_rss     = (src1.size() > 0) ? src1[0] : 70'h0;
        bif.i_rss_rdy    = rdy_v;
    endtask

    // Reference: at most two words in flight; a free slot takes whichever master is waiting,
    // alternating when both wait. A held word leaves whenever the CU is ready.
    task automatic cycle();
        bit v0, v1, take, from1, out;
        logic [69:0] w;
        drive();
        @(negedge clk);
        v0    = (src0.size() > 0);
        v1    = (src1.size() > 0);
        take  = nrst && (m_cnt < 2) && (v0 || v1);
        from1 = (v0 && v1) ? !m_last : v1;
        out   = nrst && (m_cnt > 0) && rdy_v;
        chk("m0_rd", 70'(bif.o_m0_rss_rd), 70'(take && !from1));
        chk("m1_rd", 70'(bif.o_m1_rss_rd), 70'(take && from1));
        chk("rss_wr", 70'(bif.o_rss_wr), 70'(out));
        @(posedge clk);
        if (out) m_cnt--;
        if (take) begin
            w = from1 ? src1.pop_front() : src0.pop_front();
            exp_q.push_back(w);
            m_cnt++;
            m_last = from1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (bif.o_rss_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rss_unexpected actual=%h expected=none t=%0t", bif.o_rss, $time);
            end else begin
                chk("rss_word", bif.o_rss, exp_q.pop_front());
            end
        end
    end

    initial begin
        nrst  = 1'b0;
        rdy_v = 1'b1;
        src0.push_back(rnd_word());
        src1.push_back(rnd_word());
        drive();
        #3;
        chk("rst_m0_rd", 70'(bif.o_m0_rss_rd), 70'h0);
        chk("rst_m1_rd", 70'(bif.o_m1_rss_rd), 70'h0);
        chk("rst_wr", 70'(bif.o_rss_wr), 70'h0);
        chk("rst_rss", bif.o_rss, 70'h0);
        src0.delete();
        src1.delete();
        @(posedge clk);
        #1 nrst = 1'b1;

        // single word
        src0.push_back(70'h3F_0000_0000_DEAD_BEEF);
        repeat (3) cycle();

        // contention, distinct CIDs
        for (int i = 0; i < 3; i++) begin
            src0.push_back({6'(2*i), 64'hA000_0000_0000_0000 + 64'(i)});
            src1.push_back({6'(2*i+1), 64'hB000_0000_0000_0000 + 64'(i)});
        end
        repeat (8) cycle();

        // backpressure on a Master 1 stream
        rdy_v = 1'b0;
        for (int i = 0; i < 4; i++) src1.push_back(rnd_word());
        repeat (5) cycle();
        rdy_v = 1'b1;
        repeat (6) cycle();

        // pop at full
        rdy_v = 1'b0;
        for (int i = 0; i < 4; i++) src0.push_back(rnd_word());
        repeat (3) cycle();
        rdy_v = 1'b1;
        repeat (5) cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (src0.size() < 4 && $urandom_range(0, 1) == 1) src0.push_back(rnd_word());
            if (src1.size() < 4 && $urandom_range(0, 2) != 0) src1.push_back(rnd_word());
            rdy_v = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // reset while full
        rdy_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src0.push_back(rnd_word());
            src1.push_back(rnd_word());
        end
        repeat (3) cycle();
        rdy_v = 1'b1;
        drive();
        #1;
        chk("full_wr", 70'(bif.o_rss_wr), 70'h1);
        nrst = 1'b0;
        #1;
        chk("arst_wr", 70'(bif.o_rss_wr), 70'h0);
        chk("arst_m0_rd", 70'(bif.o_m0_rss_rd), 70'h0);
        chk("arst_m1_rd", 70'(bif.o_m1_rss_rd), 70'h0);
        chk("arst_rss", bif.o_rss, 70'h0);
        m_cnt  = 0;
        m_last = 1'b1;
        exp_q.delete();
        repeat (2) cycle();
        nrst = 1'b1;
        src0.delete();
        src1.delete();
        src0.push_back({6'h11, 64'h0});
        src1.push_back({6'h22, 64'h1});
        drive();
        #1;
        chk("post_rst_m0_first", 70'(bif.o_m0_rss_rd), 70'h1);
        cycle();

        // drain
        for (int i = 0; i < 60 && (src0.size() > 0 || src1.size() > 0 || m_cnt > 0); i++) cycle();
        repeat (2) cycle();
        chk("drain_empty", 70'(exp_q.size()), 70'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vxe_mem_hub_cu_ds.md
# vxe_mem_hub_cu_ds

CU downstream traffic control for the memory hub: merges read responses returned by Master 0 and Master 1 into the single response FIFO of one compute unit (CU). It is the return-path counterpart of the CU upstream request router. A CU's requests may be routed to either master, so responses can arrive on both ports at once. The block arbitrates between the two masters round-robin and buffers up to two responses so the CU side can stall without losing data.

## Interface
- Parameters: none; all widths are fixed by the hub response format.
- Response word format, 70 bits: { 6b: CID, 64b: Data }.
- clk  in  1  clock
- nrst  in  1  reset; one clock, asynchronous, active-low
- i_m0_rss_vld  in  1  Master 0 response FIFO non-empty
- i_m0_rss  in  70  Master 0 response FIFO head
- o_m0_rss_rd  out  1  pop Master 0 response FIFO this cycle
- i_m1_rss_vld  in  1  Master 1 response FIFO non-empty
- i_m1_rss  in  70  Master 1 response FIFO head
- o_m1_rss_rd  out  1  pop Master 1 response FIFO this cycle
- i_rss_rdy  in  1  CU response FIFO can accept a word this cycle
- o_rss  out  70  response word to CU
- o_rss_wr  out  1  write o_rss into CU response FIFO this cycle

## Operation
- Internal state:
  - 2-entry response buffer with count (0..2), 1-bit rd/wr pointers and 2×70b storage.
  - last_grant flag (0 = Master 0, 1 = Master 1).
- Accept condition: count < 2. Grant is combinational from i_mX_rss_vld, count and last_grant.
  - Only M0 valid: grant M0.
  - Only M1 valid: grant M1.
  - Both valid: grant !last_grant.
- o_mX_rss_rd = accept && grant to X. At most one rd is high per cycle, and rd is never high without the matching vld.
- On a grant, the source head word is pushed into the buffer at the clock edge, and last_grant is set to the granted master. With no grant, last_grant holds.
- Output side:
  - o_rss = buffer entry at rd pointer.
  - o_rss_wr = (count != 0) && i_rss_rdy.
  - The entry pops at the clock edge when o_rss_wr is high.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Pointers wrap modulo 2.
- Words are forwarded unmodified; CID is not inspected. Ordering within one master is preserved. Ordering across masters follows grant order.

## Timing
- Reset values:
  - count = 0, pointers = 0, storage = 0, last_grant = 1, so Master 0 wins the first contention.
  - Outputs during reset: o_m0_rss_rd = 0, o_m1_rss_rd = 0, o_rss_wr = 0, o_rss = 0.
- Latency: a word popped from a master in cycle N is presented on o_rss in cycle N+1. It is written in N+1 if i_rss_rdy is high.
- Throughput: one word per cycle sustained (count steady at 1 with push and pop every cycle). With both masters valid, grants alternate M0/M1 every cycle.
- Full (count = 2): no rd is asserted, even if a pop occurs that same cycle. There is no combinational path from i_rss_rdy to o_mX_rss_rd.
- Empty (count = 0): o_rss_wr = 0 regardless of i_rss_rdy. There is no bypass from input to output.
- i_rss_rdy low: buffered words hold, o_rss stays stable, and at most 2 more words are accepted.
- Reset asserted mid-operation: buffered responses are discarded immediately and all outputs return to reset values. Master FIFO contents not yet popped are untouched.

## Test plan
- Single word: M0 presents 70'h3F_0000_0000_DEAD_BEEF for one cycle with i_rss_rdy = 1 → o_m0_rss_rd = 1 in cycle 0; o_rss_wr = 1 with the same word in cycle 1; count returns to 0.
- Contention: both masters valid for 6 cycles with distinct CIDs and rdy = 1 → grant order M0, M1, M0, M1, M0, M1; the CU receives the words in that order, one per cycle after 1-cycle latency.
- Backpressure: i_rss_rdy = 0 while M1 streams 4 words → exactly 2 rd pulses, then rd held 0. Raising rdy drains the 2 words in order, then streaming resumes with no loss or duplicate.
- Pop-at-full: count = 2 with rdy = 1 for one cycle and M0 valid → no rd that cycle; count goes to 1; rd is asserted the next cycle.
- Reset mid-stream: assert nrst low while count = 2 → o_rss_wr and rd drop asynchronously to 0. After release, the first contention grants M0.
